// File: rtl/theia_tmem_loader.sv
// Host-to-TMEM loader: buffers a linear host word stream and scatters it across interleaved banks.
// Optional running checksum of written data is built when TMEM_LOADER_CHECKSUM_EN is defined.
module theia_tmem_loader #(
    parameter int WB_WIDTH  = 32,
    parameter int BANK_BITS = 4,
    parameter int FIFO_BITS = 3
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        START_I,
    input  logic [WB_WIDTH-1:0]         BASE_I,
    input  logic [WB_WIDTH-1:0]         LEN_I,
    input  logic [WB_WIDTH-1:0]         DAT_I,
    input  logic                        STB_I,
    output logic                        ACK_O,
    input  logic                        HOLD_I,
    output logic [WB_WIDTH-1:0]         TMDAT_O,
    output logic [WB_WIDTH-1:0]         TMADR_O,
    output logic [(1<<BANK_BITS)-1:0]   TMSEL_O,
    output logic                        TMWE_O,
    output logic                        BUSY_O,
    output logic                        DONE_O,
    output logic                        ERR_O,
    output logic [WB_WIDTH-1:0]         CSUM_O
);

    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int DEPTH     = 1 << FIFO_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [WB_WIDTH-1:0]    vadr_q, vadr_d;
    logic [WB_WIDTH-1:0]    len_q, len_d;
    logic [WB_WIDTH-1:0]    acc_q, acc_d;
    logic [WB_WIDTH-1:0]    wcnt_q, wcnt_d;
    logic [WB_WIDTH-1:0]    tmdat_q, tmdat_d;
    logic [WB_WIDTH-1:0]    tmadr_q, tmadr_d;
    logic [BANK_BITS-1:0]   tmsel_q, tmsel_d;
    logic                   tmwe_q, tmwe_d;
    logic                   zdone_q, zdone_d;
    logic                   err_q, err_d;

    logic [WB_WIDTH-1:0]    fifo_q [DEPTH];
    logic [FIFO_BITS-1:0]   wptr_q, wptr_d;
    logic [FIFO_BITS-1:0]   rptr_q, rptr_d;
    logic [FIFO_BITS:0]     cnt_q, cnt_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   ack;

    assign fifo_full  = (cnt_q == (FIFO_BITS+1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        vadr_d  = vadr_q;
        len_d   = len_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        tmdat_d = tmdat_q;
        tmadr_d = tmadr_q;
        tmsel_d = tmsel_q;
        tmwe_d  = 1'b0;
        zdone_d = 1'b0;
        err_d   = err_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        pop     = 1'b0;
        ack     = STB_I && (state_q == S_LOAD) && !fifo_full && (acc_q < len_q);

        case (state_q)
            S_IDLE: begin
                if (STB_I) begin
                    err_d = 1'b1;
                end
                if (START_I) begin
                    if (LEN_I != '0) begin
                        state_d = S_LOAD;
                        vadr_d  = BASE_I;
                        len_d   = LEN_I;
                        acc_d   = '0;
                        wcnt_d  = '0;
                        err_d   = 1'b0;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (START_I || (STB_I && (acc_q == len_q))) begin
                    err_d = 1'b1;
                end
                push = ack;
                pop  = !fifo_empty && !HOLD_I;
                if (push) begin
                    wptr_d = wptr_q + FIFO_BITS'(1);
                    acc_d  = acc_q + WB_WIDTH'(1);
                end
                if (pop) begin
                    tmdat_d = fifo_q[rptr_q];
                    tmadr_d = vadr_q >> BANK_BITS;
                    tmsel_d = vadr_q[BANK_BITS-1:0];
                    tmwe_d  = 1'b1;
                    vadr_d  = vadr_q + WB_WIDTH'(1);
                    wcnt_d  = wcnt_q + WB_WIDTH'(1);
                    rptr_d  = rptr_q + FIFO_BITS'(1);
                end
                // Leave LOAD one cycle after the final write so DONE_O never overlaps TMWE_O.
                if (wcnt_q == len_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (START_I) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (FIFO_BITS+1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_BITS+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            vadr_q  <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            tmdat_q <= '0;
            tmadr_q <= '0;
            tmsel_q <= '0;
            tmwe_q  <= 1'b0;
            zdone_q <= 1'b0;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vadr_q  <= vadr_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            tmdat_q <= tmdat_d;
            tmadr_q <= tmadr_d;
            tmsel_q <= tmsel_d;
            tmwe_q  <= tmwe_d;
            zdone_q <= zdone_d;
            err_q   <= err_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge CLK_I) begin
        if (push) begin
            fifo_q[wptr_q] <= DAT_I;
        end
    end

`ifdef TMEM_LOADER_CHECKSUM_EN
    logic [WB_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE) && START_I) begin
            csum_d = '0;
        end else if (tmwe_q) begin
            csum_d = csum_q + tmdat_q;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign CSUM_O = csum_q;
`else
    assign CSUM_O = '0;
`endif

    assign ACK_O   = ack;
    assign TMDAT_O = tmdat_q;
    assign TMADR_O = tmadr_q;
    assign TMSEL_O = NUM_BANKS'(tmsel_q);
    assign TMWE_O  = tmwe_q;
    assign BUSY_O  = (state_q == S_LOAD);
    assign DONE_O  = (state_q == S_FIN) || zdone_q;
    assign ERR_O   = err_q;

endmodule

// File: tb/tb_theia_tmem_loader.sv
// Self-checking bench for theia_tmem_loader: directed scenarios plus randomized loads against a transaction-level model.
// Checksum expectations follow TMEM_LOADER_CHECKSUM_EN.
module tb_theia_tmem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] BASE = '0;
    logic [31:0] LEN = '0;
    logic [31:0] DAT = '0;
    logic        STB = 1'b0;
    logic        ACK;
    logic        HOLD = 1'b0;
    logic [31:0] TMDAT;
    logic [31:0] TMADR;
    logic [15:0] TMSEL;
    logic        TMWE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] CSUM;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] dat_a [0:31];
    int acks_hold;
    logic [31:0] last_csum;

    theia_tmem_loader #(.WB_WIDTH(32), .BANK_BITS(4), .FIFO_BITS(3)) dut (
        .CLK_I(CLK), .RST_I(RST), .START_I(START), .BASE_I(BASE), .LEN_I(LEN),
        .DAT_I(DAT), .STB_I(STB), .ACK_O(ACK), .HOLD_I(HOLD),
        .TMDAT_O(TMDAT), .TMADR_O(TMADR), .TMSEL_O(TMSEL), .TMWE_O(TMWE),
        .BUSY_O(BUSY), .DONE_O(DONE), .ERR_O(ERR), .CSUM_O(CSUM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] model_sum);
`ifdef TMEM_LOADER_CHECKSUM_EN
        return model_sum;
`else
        return 32'h0 & model_sum;
`endif
    endfunction

    // One complete load. The model tracks words accepted and words written; FIFO
    // occupancy is their difference, and word i must land at virtual address base+i.
    task automatic do_load(input logic [31:0] base, input int len, input bit use_dir,
                           input int hold_pct, input int stb_pct, input int hold_first,
                           input int glitch_at, input bit extra_stb);
        int acc_i = 0;
        int wr_i = 0;
        int occ;
        bit we_exp = 1'b0;
        bit done_exp = 1'b0;
        bit done_next;
        bit exp_err = 1'b0;
        bit exp_ack;
        bit finished = 1'b0;
        logic [31:0] va;
        logic [31:0] sum = '0;
        if (!use_dir) begin
            for (int i = 0; i < 32; i++) dat_a[i] = $urandom;
        end
        acks_hold = 0;
        START = 1'b1; BASE = base; LEN = 32'(len); STB = 1'b0; HOLD = 1'b0;
        tick();
        START = 1'b0;
        for (int c = 0; c < 400; c++) begin
            done_next = 1'b0;
            chk("tmwe", 32'(TMWE), 32'(we_exp));
            if (TMWE && wr_i < len) begin
                va = base + 32'(wr_i);
                chk("tmsel", 32'(TMSEL), 32'(va[3:0]));
                chk("tmadr", TMADR, va >> 4);
                chk("tmdat", TMDAT, dat_a[wr_i]);
                sum = sum + dat_a[wr_i];
                wr_i++;
                done_next = (wr_i == len);
            end
            chk("done", 32'(DONE), 32'(done_exp));
            chk("busy", 32'(BUSY), 32'(!done_exp));
            chk("err", 32'(ERR), 32'(exp_err));
            if (done_exp) begin
                finished = 1'b1;
                STB = 1'b0; HOLD = 1'b0; START = 1'b0;
                break;
            end
            HOLD = (c < hold_first) ? 1'b1 : ($urandom_range(99) < hold_pct);
            if (acc_i < len) STB = ($urandom_range(99) < stb_pct);
            else STB = extra_stb && ($urandom_range(99) < 30);
            DAT = (acc_i < len) ? dat_a[acc_i] : $urandom;
            START = (c == glitch_at);
            if (START) begin
                BASE = $urandom; LEN = 32'($urandom_range(1, 9));
            end
            #1;
            occ = acc_i - wr_i;
            exp_ack = STB && (occ < 8) && (acc_i < len);
            chk("ack", 32'(ACK), 32'(exp_ack));
            if (STB && acc_i == len) exp_err = 1'b1;
            if (START) exp_err = 1'b1;
            we_exp = (occ > 0) && !HOLD;
            if (exp_ack) begin
                acc_i++;
                if (c < hold_first) acks_hold++;
            end
            done_exp = done_next;
            tick();
            START = 1'b0;
        end
        if (!finished) chk("load_timeout", 32'd0, 32'd1);
        tick();
        chk("post_done", 32'(DONE), 32'd0);
        chk("post_busy", 32'(BUSY), 32'd0);
        chk("post_tmwe", 32'(TMWE), 32'd0);
        chk("post_err", 32'(ERR), 32'(exp_err));
        chk("post_wrcnt", 32'(wr_i), 32'(len));
        chk("csum", CSUM, exp_csum(sum));
        last_csum = sum;
    endtask

    initial begin
        int wcount;
        // Reset state
        #12;
        chk("rst_tmwe", 32'(TMWE), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_tmdat", TMDAT, 32'd0);
        chk("rst_tmadr", TMADR, 32'd0);
        chk("rst_tmsel", 32'(TMSEL), 32'd0);
        chk("rst_csum", CSUM, 32'd0);
        RST = 1'b0;
        tick();

        // Bank scatter across a bank-index wrap
        for (int i = 0; i < 4; i++) dat_a[i] = 32'hA0 + 32'(i);
        do_load(32'h1E, 4, 1'b1, 0, 100, 0, -1, 1'b0);
        chk("csum_dir", CSUM, exp_csum(32'h286));

        // Back-pressure: FIFO fills to eight then stalls
        do_load($urandom, 12, 1'b0, 0, 100, 14, -1, 1'b0);
        chk("hold_acks", 32'(acks_hold), 32'd8);

        // Virtual address wrap
        dat_a[0] = 32'h5A; dat_a[1] = 32'hA5;
        do_load(32'hFFFF_FFFF, 2, 1'b1, 0, 100, 0, -1, 1'b0);

        // STB in IDLE
        STB = 1'b1; DAT = 32'h1234;
        #1;
        chk("idle_ack", 32'(ACK), 32'd0);
        tick();
        STB = 1'b0;
        chk("idle_err", 32'(ERR), 32'd1);

        // Overrun STB after LEN words, START during LOAD
        do_load($urandom, 4, 1'b0, 20, 100, 0, -1, 1'b1);
        do_load($urandom, 6, 1'b0, 20, 80, 0, 1, 1'b0);

        // Zero-length load
        START = 1'b1; LEN = '0; BASE = $urandom;
        tick();
        START = 1'b0;
        chk("zl_done", 32'(DONE), 32'd1);
        chk("zl_busy", 32'(BUSY), 32'd0);
        chk("zl_tmwe", 32'(TMWE), 32'd0);
        tick();
        chk("zl_done2", 32'(DONE), 32'd0);
        chk("zl_csum", CSUM, exp_csum(last_csum) & 32'h0);

        // Asynchronous reset in the middle of a six-word load
        for (int i = 0; i < 6; i++) dat_a[i] = $urandom;
        START = 1'b1; BASE = $urandom; LEN = 32'd6;
        tick();
        START = 1'b0;
        wcount = 0;
        for (int c = 0; c < 40 && wcount < 3; c++) begin
            STB = 1'b1; DAT = dat_a[c < 6 ? c : 5];
            tick();
            if (TMWE) wcount++;
        end
        chk("rst_mid_writes", 32'(wcount), 32'd3);
        #1 RST = 1'b1;
        #1;
        chk("arst_tmwe", 32'(TMWE), 32'd0);
        chk("arst_ack", 32'(ACK), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_tmdat", TMDAT, 32'd0);
        chk("arst_tmadr", TMADR, 32'd0);
        chk("arst_tmsel", 32'(TMSEL), 32'd0);
        chk("arst_csum", CSUM, 32'd0);
        STB = 1'b0;
        tick();
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("postrst_tmwe", 32'(TMWE), 32'd0);
            chk("postrst_done", 32'(DONE), 32'd0);
            chk("postrst_err", 32'(ERR), 32'd0);
        end
        do_load($urandom, 6, 1'b0, 0, 100, 0, -1, 1'b0);

        // Randomized loads
        for (int k = 0; k < 12; k++) begin
            do_load($urandom, $urandom_range(1, 20), 1'b0, $urandom_range(0, 60),
                    $urandom_range(30, 100), 0, ($urandom_range(3) == 0) ? 1 : -1,
                    1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/theia_tmem_loader.md
Name: theia_tmem_loader

Overview:
Host-side writer for the interleaved texture memory (TMEM) banks read by the core crossbar. Accepts a linear (virtual) word stream from the host over a Wishbone-style slave handshake and buffers it in a small FIFO. Converts each virtual address into the bank index (vadr mod NUM_BANKS) plus the bank-relative physical address (vadr >> BANK_BITS), so words land where the crossbar read path expects them. Drives the GPU's TMDAT/TMADR/TMWE/TMSEL inputs.

Parameters:
WB_WIDTH, 32, data and address width.
BANK_BITS, 4, log2 of the TMEM bank count; NUM_BANKS = 1<<BANK_BITS (16).
FIFO_BITS, 3, log2 of the FIFO depth (8 entries).

Ports:
CLK_I  in  1  clock.
RST_I  in  1  reset. Asynchronous, active-high.
START_I  in  1  one-cycle pulse; starts a load. Latches BASE_I and LEN_I.
BASE_I  in  WB_WIDTH  first virtual TMEM word address.
LEN_I  in  WB_WIDTH  number of words to load.
DAT_I  in  WB_WIDTH  host write data.
STB_I  in  1  host strobe; a word is offered while high.
ACK_O  out  1  combinational accept for the current DAT_I.
HOLD_I  in  1  TMEM-side stall; while high, no TMEM write is issued.
TMDAT_O  out  WB_WIDTH  bank write data.
TMADR_O  out  WB_WIDTH  bank-relative physical address.
TMSEL_O  out  NUM_BANKS  binary bank index, zero-extended to NUM_BANKS bits.
TMWE_O  out  1  bank write enable.
BUSY_O  out  1  high in LOAD.
DONE_O  out  1  one-cycle completion pulse.
ERR_O  out  1  sticky protocol error.
CSUM_O  out  WB_WIDTH  checksum of written data (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FIFO empty, all counters 0, state IDLE. Reset asserted mid-load aborts the load, flushes the FIFO and issues no further writes.
- States: IDLE, LOAD, FIN.
- IDLE transitions:
  - START_I with LEN_I != 0: latch base to wr_vadr, len, clear acc_cnt/wr_cnt and ERR_O -> LOAD.
  - START_I with LEN_I == 0: DONE_O pulses on the next cycle, state stays IDLE.
  - STB_I high in IDLE: no ACK_O, set ERR_O.
- LOAD handshake:
  - ACK_O = STB_I & (state==LOAD) & !fifo_full & (acc_cnt < len).
  - On ACK_O the word is pushed at that clock edge and acc_cnt increments.
  - STB_I while acc_cnt == len: no ACK_O, set ERR_O.
  - No push when full, even if a pop happens in the same cycle.
- Write side, each cycle in LOAD:
  - If FIFO non-empty & !HOLD_I: pop one entry and register TMDAT_O=data, TMADR_O=wr_vadr>>BANK_BITS, TMSEL_O=wr_vadr[BANK_BITS-1:0], TMWE_O=1.
  - Then wr_vadr += 1 (wraps mod 2^WB_WIDTH) and wr_cnt += 1.
  - Otherwise TMWE_O=0; TMADR_O/TMSEL_O/TMDAT_O hold their last values.
- Latency: a word accepted at edge E0 is popped at E1 at the earliest; TMWE_O is high in the cycle after E1.
- Completion: when the last write is issued (wr_cnt reaches len), go to FIN. In FIN, TMWE_O=0 and DONE_O=1 for exactly one cycle -> IDLE.
- START_I outside IDLE is ignored and sets ERR_O.
- Simultaneous push and pop: the FIFO count is unchanged.
- Capacity: 2^FIFO_BITS entries; full/empty come from a count register, not pointer compare.

Optional Feature:
Macro TMEM_LOADER_CHECKSUM_EN.
- Defined: CSUM_O is cleared on an accepted START_I and adds TMDAT_O (mod 2^WB_WIDTH) on every cycle TMWE_O is high. It holds its value after DONE_O until the next START_I.
- Undefined: CSUM_O is tied to 0 and no adder is built.

Test Plan:
- BASE=0x1E, LEN=4, data 0xA0..0xA3, STB_I held high, HOLD_I=0:
  - writes (sel,adr,dat) = (14,1,A0), (15,1,A1), (0,2,A2), (1,2,A3), one per cycle.
  - DONE_O pulses one cycle after the last write.
  - CSUM_O=0x286 with the macro defined, 0 without.
- HOLD_I=1 for LEN=12, STB_I high:
  - exactly 8 ACK_O, then ACK_O=0 while the FIFO is full.
  - Release HOLD_I: 12 ordered writes, all 12 words accepted, DONE_O pulses once.
- BASE=0xFFFFFFFF, LEN=2 (data 0x5A, 0xA5): writes (15,0x0FFFFFFF,0x5A) then (0,0,0xA5); the address wraps.
- Protocol errors:
  - STB_I in IDLE: no ACK_O, ERR_O=1.
  - A 5th STB_I with LEN=4: no ACK_O, ERR_O=1.
  - START_I during LOAD: ignored, ERR_O=1; the next valid START_I clears ERR_O.
- RST_I asserted after 3 of 6 writes: all outputs 0 asynchronously, no further TMWE_O, no DONE_O. A new START_I then runs a clean load.
- LEN_I=0: no TMWE_O, DONE_O pulses one cycle after START_I, BUSY_O stays 0.
